fpu_result_encoder: RTL and testbench
=====================================

# fpu_result_encoder

Return-path block for the FPU interface: captures completion pulses and results from the add/subtract unit and the CORDIC unit, re-encodes the unit/mode pair into the 2-bit operation code, and queues the tagged results toward the interface. Results are delivered over a valid/ready handshake. It is the inverse of the interface's operation decode: the decode expands the operation code into per-unit mode bits, and this block folds the mode bits back into the operation code.

## Interface
- W, 32, result data width
- DEPTH, 4, result queue entries (power of two, ≥2)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- as_done  in  1  add/subt result valid, single-cycle pulse
- as_mode  in  1  add/subt mode of completing op (0 add, 1 subtract)
- as_result  in  W  add/subt result, valid with as_done
- cd_done  in  1  CORDIC result valid, single-cycle pulse
- cd_mode  in  1  CORDIC mode of completing op
- cd_result  in  W  CORDIC result, valid with cd_done
- res_ready  in  1  interface accepts result
- clr_ovf  in  1  clears sticky overflow
- res_valid  out  1  result/operation valid
- res_data  out  W  queued result at head
- res_op  out  2  encoded operation of head entry
- busy  out  1  queue non-empty
- ovf  out  1  sticky: a completion was dropped

## Operation
- Encoding: res_op = {unit, mode}; add/subt → {0, as_mode} (00 add, 01 sub); CORDIC → {1, cd_mode} (10, 11).
- Entry = {op[1:0], data[W-1:0]}; circular buffer, wr_ptr/rd_ptr width log2(DEPTH), wrap modulo DEPTH; count width log2(DEPTH)+1.
- Pop: res_valid & res_ready at a rising edge removes head.
- Free slots this cycle = DEPTH − count + pop (a pop frees a slot for a same-cycle push).
- Single done: enqueue if free ≥ 1, else drop and set ovf.
- Simultaneous as_done & cd_done: add/subt enqueued first (older), CORDIC second; free = 1 → add/subt kept, CORDIC dropped, ovf set; free = 0 → both dropped, ovf set.
- Done pulses with no free slot never corrupt stored entries or pointers.
- ovf: set on any drop; cleared by clr_ovf when no drop occurs that cycle; set wins over a simultaneous clr_ovf.
- res_valid = (count ≠ 0); res_data/res_op driven from head; held stable while res_valid & !res_ready.
- busy = res_valid.
- Reset (any time, including mid-transfer): pointers, count, ovf = 0; res_valid = 0, busy = 0, res_data = 0, res_op = 00. Queue contents are discarded.

## Timing
- Latency: done sampled at edge N → res_valid high after edge N (visible cycle N+1) when queue was empty.
- Throughput: one pop per cycle; up to two pushes per cycle.
- Simultaneous dual done into empty queue: add/subt entry at head cycle N+1; CORDIC entry at head the cycle after its pop.
- Full queue with pop and one done in the same cycle: push accepted, count unchanged, no overflow.
- res_ready may be high while res_valid is low; no effect.
- No combinational path from res_ready to res_valid/res_data/res_op.

## Structure
- Shared package fpu_op_pkg: OP_ADD = 2'b00, OP_SUB = 2'b01, OP_CORDIC_M0 = 2'b10, OP_CORDIC_M1 = 2'b11, unit-bit index, entry struct {op, data}. The same package serves the interface operation decode.
- One sub-module: fpu_result_fifo (DEPTH × (W+2), dual-push/single-pop, exports count/free). The top holds encoding, push ordering and overflow logic.

## Test plan
- Reset mid-stream: 3 entries queued, rst low for 1 cycle → res_valid = 0, res_op = 00, res_data = 0, ovf = 0; the next as_done is delivered alone.
- as_done, as_mode = 1, as_result = 32'h4049_0FDB, res_ready = 1 → next cycle res_valid = 1, res_op = 01, res_data = 32'h4049_0FDB; gone one cycle later.
- Same-cycle as_done (mode 0, 32'h1) and cd_done (mode 1, 32'h2), res_ready = 0 → outputs (00, 32'h1) stable; raise res_ready → then (11, 32'h2).
- Fill 4 entries with res_ready = 0; then cd_done → ovf = 1, head unchanged, count = 4. clr_ovf → ovf = 0.
- Queue full with res_ready = 1 and as_done in the same cycle → pop and push both occur, count stays 4, ovf stays 0.
- count = 3 with dual done → add/subt stored, CORDIC dropped, ovf = 1; draining yields exactly 4 entries in order.

Source files
------------

// File: rtl/fpu_op_pkg.sv
// Operation codes shared by the FPU interface decode and the result return path.
// An op code is {unit, mode}: unit 0 = add/subtract, unit 1 = CORDIC.
package fpu_op_pkg;
  localparam int FPU_W = 32;
  localparam int OP_UNIT_BIT = 1;

  localparam logic [1:0] OP_ADD       = 2'b00;
  localparam logic [1:0] OP_SUB       = 2'b01;
  localparam logic [1:0] OP_CORDIC_M0 = 2'b10;
  localparam logic [1:0] OP_CORDIC_M1 = 2'b11;

  typedef struct packed {
    logic [1:0]       op;
    logic [FPU_W-1:0] data;
  } fpu_res_t;

  function automatic logic [1:0] enc_op(input logic unit, input logic mode);
    logic [1:0] op;
    op = 2'b00;
    op[OP_UNIT_BIT] = unit;
    op[0] = mode;
    return op;
  endfunction
endpackage

// File: rtl/fpu_result_fifo.sv
// Circular result queue: up to two pushes (slot 0 older) and one pop per cycle.
// Callers only push what o_free allows; head reads as zero when empty.
module fpu_result_fifo #(
  parameter int EW    = 34,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push0,
  input  logic [EW-1:0] i_data0,
  input  logic          i_push1,
  input  logic [EW-1:0] i_data1,
  input  logic          i_pop,
  output logic [EW-1:0] o_head,
  output logic [CW-1:0] o_count,
  output logic [CW-1:0] o_free
);
  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [AW-1:0] w_wr1;

  // Second push lands after the first when both are present.
  assign w_wr1 = r_wr_ptr + AW'(i_push0);

  always_ff @(posedge i_clk) begin
    if (i_push0) r_mem[r_wr_ptr] <= i_data0;
    if (i_push1) r_mem[w_wr1]    <= i_data1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(i_push0) + AW'(i_push1);
      r_rd_ptr <= r_rd_ptr + AW'(i_pop);
      r_count  <= r_count + CW'(i_push0) + CW'(i_push1) - CW'(i_pop);
    end
  end

  assign o_count = r_count;
  assign o_free  = CW'(DEPTH) - r_count + CW'(i_pop);
  assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
endmodule

// File: rtl/fpu_result_encoder.sv
// FPU return path: folds unit/mode back into the op code and queues tagged
// results toward the interface, tracking dropped completions in a sticky flag.
module fpu_result_encoder
  import fpu_op_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_as_done,
  input  logic         i_as_mode,
  input  logic [W-1:0] i_as_result,
  input  logic         i_cd_done,
  input  logic         i_cd_mode,
  input  logic [W-1:0] i_cd_result,
  input  logic         i_res_ready,
  input  logic         i_clr_ovf,
  output logic         o_res_valid,
  output logic [W-1:0] o_res_data,
  output logic [1:0]   o_res_op,
  output logic         o_busy,
  output logic         o_ovf
);
  logic [W+1:0]  w_as_ent, w_cd_ent, w_data0, w_head;
  logic [CW-1:0] w_count, w_free;
  logic          w_pop, w_keep_as, w_keep_cd, w_drop, w_push0, w_push1;
  logic          r_ovf;

  assign w_as_ent = {enc_op(1'b0, i_as_mode), i_as_result};
  assign w_cd_ent = {enc_op(1'b1, i_cd_mode), i_cd_result};

  assign o_res_valid = (w_count != '0);
  assign w_pop       = o_res_valid & i_res_ready;

  // Add/subt is the older result: it claims the first free slot.
  assign w_keep_as = i_as_done & (w_free >= CW'(1));
  assign w_keep_cd = i_cd_done & (w_free >= (i_as_done ? CW'(2) : CW'(1)));
  assign w_drop    = (i_as_done & !w_keep_as) | (i_cd_done & !w_keep_cd);

  assign w_push0 = w_keep_as | w_keep_cd;
  assign w_data0 = w_keep_as ? w_as_ent : w_cd_ent;
  assign w_push1 = w_keep_as & w_keep_cd;

  fpu_result_fifo #(.EW(W + 2), .DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push0 (w_push0),
    .i_data0 (w_data0),
    .i_push1 (w_push1),
    .i_data1 (w_cd_ent),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_free  (w_free)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       r_ovf <= 1'b0;
    else if (w_drop)    r_ovf <= 1'b1;
    else if (i_clr_ovf) r_ovf <= 1'b0;
  end

  assign o_res_op   = w_head[W+1:W];
  assign o_res_data = w_head[W-1:0];
  assign o_busy     = o_res_valid;
  assign o_ovf      = r_ovf;
endmodule

// File: tb/tb_fpu_result_encoder.sv
// Directed bench for fpu_result_encoder; expected values are hand-derived.
module tb_fpu_result_encoder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        as_done, as_mode, cd_done, cd_mode, res_ready, clr_ovf;
  logic [31:0] as_result, cd_result;
  logic        res_valid, busy, ovf;
  logic [31:0] res_data;
  logic [1:0]  res_op;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fpu_result_encoder #(.W(32), .DEPTH(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_as_done(as_done), .i_as_mode(as_mode), .i_as_result(as_result),
    .i_cd_done(cd_done), .i_cd_mode(cd_mode), .i_cd_result(cd_result),
    .i_res_ready(res_ready), .i_clr_ovf(clr_ovf),
    .o_res_valid(res_valid), .o_res_data(res_data), .o_res_op(res_op),
    .o_busy(busy), .o_ovf(ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // head = {valid, op, data}
  function automatic logic [63:0] head();
    return {29'd0, res_valid, res_op, res_data};
  endfunction

  function automatic logic [63:0] hv(input logic [1:0] op, input logic [31:0] d);
    return {29'd0, 1'b1, op, d};
  endfunction

  task automatic as_push(input logic m, input logic [31:0] d);
    as_done = 1'b1; as_mode = m; as_result = d;
  endtask

  task automatic cd_push(input logic m, input logic [31:0] d);
    cd_done = 1'b1; cd_mode = m; cd_result = d;
  endtask

  task automatic idle();
    as_done = 1'b0; cd_done = 1'b0; clr_ovf = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; res_ready = 1'b0;
    as_mode = 1'b0; cd_mode = 1'b0; as_result = '0; cd_result = '0;
    idle();
    tick(); tick();
    chk("reset_head", head(), 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_ovf", {63'd0, ovf}, 64'd0);
    rst_n = 1'b1;
    tick();

    // single subtract result, immediately consumed
    res_ready = 1'b1;
    as_push(1'b1, 32'h4049_0FDB);
    tick(); idle();
    chk("sub_head", head(), hv(2'b01, 32'h4049_0FDB));
    chk("sub_busy", {63'd0, busy}, 64'd1);
    tick();
    chk("sub_gone", {63'd0, res_valid}, 64'd0);

    // simultaneous completions, add/subt first
    res_ready = 1'b0;
    as_push(1'b0, 32'h1); cd_push(1'b1, 32'h2);
    tick(); idle();
    chk("dual_first", head(), hv(2'b00, 32'h1));
    tick();
    chk("dual_hold", head(), hv(2'b00, 32'h1));
    res_ready = 1'b1;
    tick();
    chk("dual_second", head(), hv(2'b11, 32'h2));
    tick();
    chk("dual_empty", {63'd0, res_valid}, 64'd0);

    // fill to 4, then overflow with simultaneous clear (set wins)
    res_ready = 1'b0;
    as_push(1'b0, 32'h10); cd_push(1'b0, 32'h11);
    tick(); idle();
    as_push(1'b1, 32'h12); cd_push(1'b1, 32'h13);
    tick(); idle();
    chk("full_ovf0", {63'd0, ovf}, 64'd0);
    cd_push(1'b1, 32'h99); clr_ovf = 1'b1;
    tick(); idle();
    chk("ovf_set", {63'd0, ovf}, 64'd1);
    chk("ovf_head", head(), hv(2'b00, 32'h10));
    clr_ovf = 1'b1;
    tick(); idle();
    chk("ovf_clr", {63'd0, ovf}, 64'd0);

    // full + pop + push in the same cycle
    res_ready = 1'b1;
    as_push(1'b1, 32'h20);
    tick(); idle();
    chk("fullpp_ovf", {63'd0, ovf}, 64'd0);
    chk("fullpp_h1", head(), hv(2'b10, 32'h11));
    tick();
    chk("fullpp_h2", head(), hv(2'b01, 32'h12));
    tick();
    chk("fullpp_h3", head(), hv(2'b11, 32'h13));
    tick();
    chk("fullpp_h4", head(), hv(2'b01, 32'h20));
    tick();
    chk("fullpp_empty", {63'd0, res_valid}, 64'd0);

    // count = 3 with dual completion: CORDIC dropped
    res_ready = 1'b0;
    as_push(1'b0, 32'h30); tick(); idle();
    as_push(1'b0, 32'h31); tick(); idle();
    as_push(1'b0, 32'h32); tick(); idle();
    as_push(1'b1, 32'h33); cd_push(1'b0, 32'h34);
    tick(); idle();
    chk("c3_ovf", {63'd0, ovf}, 64'd1);
    chk("c3_h1", head(), hv(2'b00, 32'h30));
    res_ready = 1'b1;
    tick();
    chk("c3_h2", head(), hv(2'b00, 32'h31));
    tick();
    chk("c3_h3", head(), hv(2'b00, 32'h32));
    tick();
    chk("c3_h4", head(), hv(2'b01, 32'h33));
    tick();
    chk("c3_empty", {63'd0, res_valid}, 64'd0);

    // asynchronous reset with 3 entries queued and ovf still set
    res_ready = 1'b0;
    as_push(1'b1, 32'h40); tick(); idle();
    as_push(1'b0, 32'h41); tick(); idle();
    as_push(1'b1, 32'h42); tick(); idle();
    chk("pre_rst_head", head(), hv(2'b01, 32'h40));
    rst_n = 1'b0;
    #1;
    chk("rst_async_head", head(), 64'd0);
    chk("rst_async_ovf", {63'd0, ovf}, 64'd0);
    tick();
    rst_n = 1'b1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    as_push(1'b0, 32'h55);
    tick(); idle();
    chk("post_rst_head", head(), hv(2'b00, 32'h55));
    res_ready = 1'b1;
    tick();
    chk("post_rst_alone", {63'd0, res_valid}, 64'd0);
    chk("post_rst_ovf", {63'd0, ovf}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
